enc_delta_fifo: RTL and testbench
=================================

Name: enc_delta_fifo

Overview:
- Sits directly downstream of the encoder counter stage.
- Consumes its 64-bit count, overflow flag and single-cycle ready strobe.
- On each strobe, computes the 64-bit delta from the previous captured count and queues {first, ovf, delta} in a FIFO.
- Serialises each queued record as 32-bit words over a valid/ready stream to the DAQ readout path.

Parameters:
- P_ADDR_W, 4, FIFO address width; depth = 2**P_ADDR_W records (default 16).
- P_DROP_W, 16, width of the saturating dropped-sample counter.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- I_RST  input  1  reset, asynchronous, active-high.
- I_ARM  input  1  arm level shared with the counter stage; low = disarmed.
- I_CNT  input  64  count from the counter stage.
- I_OVERFLOW  input  1  overflow flag from the counter stage.
- I_READY  input  1  capture strobe from the counter stage, one cycle wide.
- O_DATA  output  32  readout word.
- O_VALID  output  1  O_DATA is valid.
- O_LAST  output  1  marks the final word of a record.
- I_RDY  input  1  consumer accepts the word; a transfer occurs when O_VALID && I_RDY.
- O_FULL  output  1  FIFO holds 2**P_ADDR_W records.
- O_EMPTY  output  1  FIFO holds 0 records.
- O_DROP_CNT  output  P_DROP_W  count of strobes lost because the FIFO was full.

Behaviour:
- Reset (I_RST=1, asynchronous):
  - pointers and occupancy = 0; r_prev = 0; r_first = 1.
  - output FSM = S_IDLE.
  - O_DATA = 0, O_VALID = 0, O_LAST = 0, O_FULL = 0, O_EMPTY = 1, O_DROP_CNT = 0.
- Disarm (I_ARM=0, synchronous):
  - r_prev <= 0 and r_first <= 1.
  - Any I_READY in that cycle is ignored.
  - FIFO contents and readout continue unaffected.
- Capture (I_ARM=1 && I_READY=1 at edge N):
  - delta = I_CNT - r_prev, modulo 2**64 (a wrap yields the correct modular difference).
  - Record written = {first=r_first, ovf=I_OVERFLOW, delta}.
  - r_prev <= I_CNT; r_first <= 0.
  - r_prev and r_first update even if the record is dropped.
- Drop: if the FIFO is full and no record is freed at the same edge, the record is discarded and O_DROP_CNT increments, saturating at all-ones.
- Simultaneous push and pop: if the record is freed (LO word transferred) at the same edge as a capture while full, the capture is accepted and occupancy stays full.
- Latency: a capture at edge N into an empty FIFO gives O_VALID=1 in the cycle after edge N.
- Output FSM, with a record popped only on the LO transfer:
  - S_IDLE: if the FIFO is not empty, go to S_HI.
  - S_HI: O_DATA = {first, ovf, 14'b0, delta[63:48]}, O_LAST = 0. On transfer, go to S_MID.
  - S_MID: O_DATA = delta[47:16], O_LAST = 0. On transfer, go to S_LO.
  - S_LO: O_DATA = {delta[15:0], 16'h0000}, O_LAST = 1. On transfer, pop; go to S_HI if more records remain after the pop, else S_IDLE.
- Output register rules:
  - O_DATA, O_VALID and O_LAST are registered.
  - O_VALID stays high until the transfer; O_DATA is held stable while O_VALID && !I_RDY.
  - Back-to-back records carry no idle cycle.
- Flags: O_FULL and O_EMPTY reflect occupancy after each edge.
- Reset mid-record: the partial record is abandoned and O_VALID drops immediately.

Optional Feature:
- ENC_DELTA_TSTAMP_EN defined:
  - A free-running 32-bit cycle counter (reset 0, wraps) is sampled at capture and stored with the record.
  - A fourth state S_TS follows S_LO with O_DATA = timestamp.
  - O_LAST moves from S_LO to S_TS; the pop occurs on the S_TS transfer.
- Not defined: three-word records exactly as in Behaviour; no timestamp logic.

Test Plan:
- Reset, arm, strobe with I_CNT=100, then I_CNT=250 -> records {first=1, delta=100} and {first=0, delta=150}; words 0x80000000, 0x00000000, 0x00640000, then first word 0x00000000 for the second record.
- Strobe with I_CNT=0xFFFFFFFFFFFFFFF0, then I_CNT=0x10 with I_OVERFLOW=1 -> second record delta=0x20, ovf=1, HI word 0x40000000.
- Hold I_RDY=0, issue 18 strobes -> O_FULL=1 after 16; O_DROP_CNT=2; release I_RDY=1 -> exactly 48 words drain, O_EMPTY=1.
- FIFO full with LO word transferring at the same edge as a strobe -> strobe accepted, O_DROP_CNT unchanged, O_FULL stays 1.
- Drop I_ARM for 1 cycle between strobes, then strobe with I_CNT=7 -> record first=1, delta=7.
- Assert I_RST while in S_MID with O_VALID=1 -> O_VALID=0 asynchronously; O_EMPTY=1, O_DROP_CNT=0 after release.

Source files
------------

// File: rtl/enc_delta_fifo.sv
// Delta-encoding capture FIFO: turns counter-stage strobes into {first, ovf, delta}
// records and streams each one as 32-bit words. Optional timestamp word: ENC_DELTA_TSTAMP_EN.
module enc_delta_fifo #(
  parameter int P_ADDR_W = 4,
  parameter int P_DROP_W = 16
) (
  input  logic                CLK,
  input  logic                I_RST,
  input  logic                I_ARM,
  input  logic [63:0]         I_CNT,
  input  logic                I_OVERFLOW,
  input  logic                I_READY,
  output logic [31:0]         O_DATA,
  output logic                O_VALID,
  output logic                O_LAST,
  input  logic                I_RDY,
  output logic                O_FULL,
  output logic                O_EMPTY,
  output logic [P_DROP_W-1:0] O_DROP_CNT
);

  localparam int                LP_DEPTH    = 1 << P_ADDR_W;
  localparam logic [P_ADDR_W:0] LP_FULL_CNT = (P_ADDR_W+1)'(LP_DEPTH);
  localparam logic [P_ADDR_W:0] LP_ONE      = (P_ADDR_W+1)'(1);

  typedef struct packed {
    logic        first;
    logic        ovf;
    logic [63:0] delta;
`ifdef ENC_DELTA_TSTAMP_EN
    logic [31:0] ts;
`endif
  } rec_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HI   = 3'd1,
    S_MID  = 3'd2,
    S_LO   = 3'd3
`ifdef ENC_DELTA_TSTAMP_EN
    ,S_TS  = 3'd4
`endif
  } state_t;

`ifdef ENC_DELTA_TSTAMP_EN
  localparam state_t LP_POP_STATE = S_TS;
`else
  localparam state_t LP_POP_STATE = S_LO;
`endif

  rec_t                mem_q [LP_DEPTH];
  logic [P_ADDR_W-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
  logic [P_ADDR_W:0]   cnt_q, cnt_d;
  logic [63:0]         prev_q;
  logic                first_q;
  logic [P_DROP_W-1:0] drop_q;
  state_t              state_q, state_d;
  logic [31:0]         data_q, data_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;

  logic capture, full, empty, xfer, pop, push, drop, more_after_pop;
  rec_t wr_rec, head_rec, next_rec;

`ifdef ENC_DELTA_TSTAMP_EN
  logic [31:0] ts_q;

  always_ff @(posedge CLK or posedge I_RST) begin
    if (I_RST) ts_q <= '0;
    else       ts_q <= ts_q + 32'd1;
  end
`endif

  function automatic logic [31:0] hi_word(input rec_t r);
    return {r.first, r.ovf, 14'b0, r.delta[63:48]};
  endfunction

  function automatic logic [31:0] mid_word(input rec_t r);
    return r.delta[47:16];
  endfunction

  function automatic logic [31:0] lo_word(input rec_t r);
    return {r.delta[15:0], 16'h0000};
  endfunction

  assign capture    = I_ARM & I_READY;
  assign full       = (cnt_q == LP_FULL_CNT);
  assign empty      = (cnt_q == '0);
  assign xfer       = valid_q & I_RDY;
  assign pop        = xfer & (state_q == LP_POP_STATE);
  // A full FIFO still accepts a capture when the head record leaves on the same edge.
  assign push       = capture & (~full | pop);
  assign drop       = capture & full & ~pop;
  assign rd_ptr_nxt = rd_ptr_q + 1'b1;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    wr_rec       = '0;
    wr_rec.first = first_q;
    wr_rec.ovf   = I_OVERFLOW;
    wr_rec.delta = I_CNT - prev_q;
`ifdef ENC_DELTA_TSTAMP_EN
    wr_rec.ts    = ts_q;
`endif
  end

  // Head and successor bypass the array when the record is being written this edge.
  assign head_rec       = empty ? wr_rec : mem_q[rd_ptr_q];
  assign next_rec       = (cnt_q > LP_ONE) ? mem_q[rd_ptr_nxt] : wr_rec;
  assign more_after_pop = (cnt_q > LP_ONE) | push;

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge I_RST) begin
    if (I_RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      prev_q   <= '0;
      first_q  <= 1'b1;
      drop_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_nxt;
      if (!I_ARM) begin
        prev_q  <= '0;
        first_q <= 1'b1;
      end else if (I_READY) begin
        prev_q  <= I_CNT;
        first_q <= 1'b0;
      end
      if (drop && (drop_q != '1)) drop_q <= drop_q + 1'b1;
    end
  end

  // NOTE: the record array has no reset; occupancy and pointers alone decide what is valid.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= wr_rec;
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (!empty || push) begin
          state_d = S_HI;
          data_d  = hi_word(head_rec);
          valid_d = 1'b1;
          last_d  = 1'b0;
        end
      end
      S_HI: begin
        if (xfer) begin
          state_d = S_MID;
          data_d  = mid_word(head_rec);
          last_d  = 1'b0;
        end
      end
      S_MID: begin
        if (xfer) begin
          state_d = S_LO;
          data_d  = lo_word(head_rec);
`ifdef ENC_DELTA_TSTAMP_EN
          last_d  = 1'b0;
`else
          last_d  = 1'b1;
`endif
        end
      end
`ifdef ENC_DELTA_TSTAMP_EN
      S_LO: begin
        if (xfer) begin
          state_d = S_TS;
          data_d  = head_rec.ts;
          last_d  = 1'b1;
        end
      end
      S_TS: begin
`else
      S_LO: begin
`endif
        if (xfer) begin
          if (more_after_pop) begin
            state_d = S_HI;
            data_d  = hi_word(next_rec);
            valid_d = 1'b1;
          end else begin
            state_d = S_IDLE;
            data_d  = '0;
            valid_d = 1'b0;
          end
          last_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        data_d  = '0;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge I_RST) begin
    if (I_RST) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign O_DATA     = data_q;
  assign O_VALID    = valid_q;
  assign O_LAST     = last_q;
  assign O_FULL     = full;
  assign O_EMPTY    = empty;
  assign O_DROP_CNT = drop_q;

endmodule

// File: tb/tb_enc_delta_fifo.sv
// Scoreboard bench for enc_delta_fifo: stimulus queues hand-computed words,
// a negedge monitor pops and compares every accepted output word.
module tb_enc_delta_fifo;

  logic        CLK = 1'b0;
  logic        I_RST, I_ARM, I_OVERFLOW, I_READY, I_RDY;
  logic [63:0] I_CNT;
  logic [31:0] O_DATA;
  logic        O_VALID, O_LAST, O_FULL, O_EMPTY;
  logic [15:0] O_DROP_CNT;

  always #5 CLK = ~CLK;

  enc_delta_fifo #(.P_ADDR_W(4), .P_DROP_W(16)) dut (
    .CLK(CLK), .I_RST(I_RST), .I_ARM(I_ARM), .I_CNT(I_CNT),
    .I_OVERFLOW(I_OVERFLOW), .I_READY(I_READY), .O_DATA(O_DATA),
    .O_VALID(O_VALID), .O_LAST(O_LAST), .I_RDY(I_RDY), .O_FULL(O_FULL),
    .O_EMPTY(O_EMPTY), .O_DROP_CNT(O_DROP_CNT)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_words  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic void push_exp(input logic [31:0] data, input logic last);
    exp_t e;
    e.data = data;
    e.last = last;
    sb.push_back(e);
  endfunction

  function automatic void push_rec(input logic first, input logic ovf, input logic [63:0] delta);
    push_exp({first, ovf, 14'b0, delta[63:48]}, 1'b0);
    push_exp(delta[47:16], 1'b0);
    push_exp({delta[15:0], 16'h0000}, 1'b1);
  endfunction

  always @(negedge CLK) begin
    if (!I_RST && O_VALID && I_RDY) begin
      n_words++;
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_word: got 0x%0h expected no word", O_DATA);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("word_data", {32'h0, O_DATA}, {32'h0, e.data});
        check("word_last", {63'h0, O_LAST}, {63'h0, e.last});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic strobe(input logic [63:0] cnt, input logic ovf);
    I_CNT      = cnt;
    I_OVERFLOW = ovf;
    I_READY    = 1'b1;
    tick();
    I_READY    = 1'b0;
    I_OVERFLOW = 1'b0;
  endtask

  task automatic disarm();
    I_ARM = 1'b0;
    tick();
    I_ARM = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (sb.size() == 0 && O_EMPTY && !O_VALID) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    check(name, {63'h0, done}, 64'h1);
  endtask

  initial begin
    int  w0;
    logic found;
    I_RST = 1'b1; I_ARM = 1'b0; I_CNT = '0; I_OVERFLOW = 1'b0;
    I_READY = 1'b0; I_RDY = 1'b0;
    tick(); tick();
    check("rst_valid", {63'h0, O_VALID}, 64'h0);
    check("rst_last",  {63'h0, O_LAST},  64'h0);
    check("rst_data",  {32'h0, O_DATA},  64'h0);
    check("rst_full",  {63'h0, O_FULL},  64'h0);
    check("rst_empty", {63'h0, O_EMPTY}, 64'h1);
    check("rst_drop",  {48'h0, O_DROP_CNT}, 64'h0);
    I_RST = 1'b0;
    tick();
    I_ARM = 1'b1;
    tick();

    // First record after arming, then a plain delta.
    I_RDY = 1'b1;
    push_exp(32'h8000_0000, 1'b0); push_exp(32'h0000_0000, 1'b0); push_exp(32'h0064_0000, 1'b1);
    push_exp(32'h0000_0000, 1'b0); push_exp(32'h0000_0000, 1'b0); push_exp(32'h0096_0000, 1'b1);
    strobe(64'd100, 1'b0);
    check("latency_valid", {63'h0, O_VALID}, 64'h1);
    check("latency_data",  {32'h0, O_DATA},  64'h8000_0000);
    check("not_empty",     {63'h0, O_EMPTY}, 64'h0);
    strobe(64'd250, 1'b0);
    wait_drain("drain_basic");

    // Modular wrap of the count with overflow flag.
    disarm();
    push_exp(32'h8000_FFFF, 1'b0); push_exp(32'hFFFF_FFFF, 1'b0); push_exp(32'hFFF0_0000, 1'b1);
    push_exp(32'h4000_0000, 1'b0); push_exp(32'h0000_0000, 1'b0); push_exp(32'h0020_0000, 1'b1);
    strobe(64'hFFFF_FFFF_FFFF_FFF0, 1'b0);
    strobe(64'h10, 1'b1);
    wait_drain("drain_wrap");

    // Fill with a stalled consumer: 16 accepted, 2 dropped.
    I_RDY = 1'b0;
    disarm();
    for (int i = 0; i < 18; i++) begin
      if (i < 16) push_rec(i == 0, 1'b0, 64'd10);
      strobe(64'(10 * (i + 1)), 1'b0);
      if (i == 14) check("not_full_15", {63'h0, O_FULL}, 64'h0);
      if (i == 15) check("full_16",     {63'h0, O_FULL}, 64'h1);
    end
    check("drop_cnt_2", {48'h0, O_DROP_CNT}, 64'h2);
    check("full_held",  {63'h0, O_FULL},     64'h1);
    w0 = n_words;
    I_RDY = 1'b1;
    wait_drain("drain_full");
    check("drain_words", 64'(n_words - w0), 64'd48);
    check("empty_after", {63'h0, O_EMPTY}, 64'h1);

    // Full FIFO: capture coincides with the LO transfer.
    I_RDY = 1'b0;
    disarm();
    for (int i = 0; i < 16; i++) begin
      push_rec(i == 0, 1'b0, 64'd20);
      strobe(64'(20 * (i + 1)), 1'b0);
    end
    check("full_again", {63'h0, O_FULL}, 64'h1);
    I_RDY = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (O_VALID && O_LAST) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("lo_reached", {63'h0, found}, 64'h1);
    push_rec(1'b0, 1'b0, 64'd20);
    strobe(64'd340, 1'b0);
    check("simul_full", {63'h0, O_FULL},     64'h1);
    check("simul_drop", {48'h0, O_DROP_CNT}, 64'h2);
    wait_drain("drain_simul");

    // One-cycle disarm restarts the delta chain.
    disarm();
    push_exp(32'h8000_0000, 1'b0); push_exp(32'h0000_0000, 1'b0); push_exp(32'h01F4_0000, 1'b1);
    strobe(64'd500, 1'b0);
    I_ARM = 1'b0;
    tick();
    I_ARM = 1'b1;
    push_exp(32'h8000_0000, 1'b0); push_exp(32'h0000_0000, 1'b0); push_exp(32'h0007_0000, 1'b1);
    strobe(64'd7, 1'b0);
    wait_drain("drain_disarm");

    // Reset while the MID word is waiting.
    I_RDY = 1'b0;
    disarm();
    push_exp(32'h8000_0000, 1'b0);
    strobe(64'h12345, 1'b0);
    I_RDY = 1'b1;
    tick();
    I_RDY = 1'b0;
    check("mid_valid", {63'h0, O_VALID}, 64'h1);
    check("mid_data",  {32'h0, O_DATA},  64'h1);
    check("mid_last",  {63'h0, O_LAST},  64'h0);
    #2 I_RST = 1'b1;
    #1 check("rst_async_valid", {63'h0, O_VALID}, 64'h0);
    tick();
    I_RST = 1'b0;
    tick();
    check("post_rst_empty", {63'h0, O_EMPTY},     64'h1);
    check("post_rst_drop",  {48'h0, O_DROP_CNT}, 64'h0);
    check("post_rst_valid", {63'h0, O_VALID},     64'h0);
    check("sb_empty_end",   64'(sb.size()),       64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
